// File: rtl/kan_tda_bist_sequencer.sv
// BIST sequencer for the KAN/TDA compute array: LFSR stimulus over a valid/ready
// handshake, MISR response compaction, per-vector watchdog and golden compare.
module kan_tda_bist_sequencer #(
    parameter int          DATA_WIDTH     = 16,
    parameter int          NUM_LANES      = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] LFSR_SEED      = 32'h0000ACE1
) (
    input  logic                            sys_clk,
    input  logic                            por_rst_n,
    input  logic                            bist_start,
    input  logic                            bist_abort,
    input  logic [15:0]                     cfg_num_vectors,
    input  logic [31:0]                     cfg_golden_sig,
    output logic [NUM_LANES*DATA_WIDTH-1:0] stim_data,
    output logic                            stim_valid,
    input  logic                            stim_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] resp_data,
    input  logic                            resp_valid,
    output logic                            bist_busy,
    output logic                            bist_done,
    output logic                            bist_pass,
    output logic                            bist_timeout,
    output logic                            bist_spurious,
    output logic [15:0]                     vec_count,
    output logic [31:0]                     signature
);

    localparam int BUS_W = NUM_LANES * DATA_WIDTH;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEED  = 3'd1;
    localparam logic [2:0] ST_DRIVE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        lfsr_step = cur[0] ? ((cur >> 1) ^ 32'h80200003) : (cur >> 1);
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] f);
        misr_step = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C11DB7 : 32'h00000000) ^ f;
    endfunction

    function automatic logic [31:0] fold_lanes(input logic [BUS_W-1:0] d);
        logic [31:0] acc;
        acc = 32'h00000000;
        for (int k = 0; k < NUM_LANES; k++) begin
            acc = acc ^ 32'(d[k*DATA_WIDTH +: DATA_WIDTH]);
        end
        fold_lanes = acc;
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [31:0]      lfsr_r;
    logic [WD_W-1:0]  wd_cnt_r;
    logic [BUS_W-1:0] lanes_s;
    logic             last_vec_s;

    assign last_vec_s = (({1'b0, vec_count} + 17'd1) == {1'b0, cfg_num_vectors});

    // Lane k is the low LFSR slice with the lane index folded in.
    always_comb begin
        lanes_s = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lanes_s[k*DATA_WIDTH +: DATA_WIDTH] = lfsr_r[DATA_WIDTH-1:0] ^ DATA_WIDTH'(k);
        end
    end

    // Stimulus bus reads zero whenever no vector is being offered.
    assign stim_data = stim_valid ? lanes_s : {BUS_W{1'b0}};

    // Next-state selection; abort overrides everything, including start.
    always_comb begin
        state_nxt_s = state_r;
        if (bist_abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  if (bist_start) state_nxt_s = ST_SEED; else state_nxt_s = ST_IDLE;
                ST_SEED:  if (cfg_num_vectors == 16'd0) state_nxt_s = ST_CHECK; else state_nxt_s = ST_DRIVE;
                ST_DRIVE: if (stim_ready) state_nxt_s = ST_WAIT; else state_nxt_s = ST_DRIVE;
                ST_WAIT: begin
                    if (resp_valid) begin
                        if (last_vec_s) state_nxt_s = ST_CHECK; else state_nxt_s = ST_DRIVE;
                    end else if (wd_cnt_r == WD_LAST) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_CHECK: state_nxt_s = ST_DONE;
                ST_DONE:  if (bist_start) state_nxt_s = ST_SEED; else state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, decoded status flops, LFSR, MISR, watchdog and sticky flags.
    always_ff @(posedge sys_clk or negedge por_rst_n) begin
        if (!por_rst_n) begin
            state_r       <= ST_IDLE;
            stim_valid    <= 1'b0;
            bist_busy     <= 1'b0;
            bist_done     <= 1'b0;
            bist_pass     <= 1'b0;
            bist_timeout  <= 1'b0;
            bist_spurious <= 1'b0;
            vec_count     <= 16'h0000;
            signature     <= 32'hFFFFFFFF;
            lfsr_r        <= LFSR_SEED;
            wd_cnt_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            stim_valid <= (state_nxt_s == ST_DRIVE);
            bist_busy  <= (state_nxt_s == ST_SEED) || (state_nxt_s == ST_DRIVE) ||
                          (state_nxt_s == ST_WAIT);
            bist_done  <= (state_nxt_s == ST_DONE);
            if (bist_abort) begin
                // Counters, signature and sticky flags stay frozen for debug.
                bist_pass <= 1'b0;
                wd_cnt_r  <= '0;
            end else begin
                case (state_r)
                    ST_SEED: begin
                        lfsr_r        <= LFSR_SEED;
                        signature     <= 32'hFFFFFFFF;
                        vec_count     <= 16'h0000;
                        bist_timeout  <= 1'b0;
                        bist_pass     <= 1'b0;
                        bist_spurious <= resp_valid;
                        wd_cnt_r      <= '0;
                    end
                    ST_DRIVE: begin
                        wd_cnt_r <= '0;
                        if (stim_ready) lfsr_r <= lfsr_step(lfsr_r);
                        if (resp_valid) bist_spurious <= 1'b1;
                    end
                    ST_WAIT: begin
                        if (resp_valid) begin
                            signature <= misr_step(signature, fold_lanes(resp_data));
                            if (vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
                            wd_cnt_r  <= '0;
                        end else if (wd_cnt_r == WD_LAST) begin
                            bist_timeout <= 1'b1;
                        end else begin
                            wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_CHECK: begin
                        bist_pass <= (signature == cfg_golden_sig) && !bist_timeout && !bist_spurious;
                        if (resp_valid) bist_spurious <= 1'b1;
                    end
                    default: begin
                        wd_cnt_r <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kan_tda_bist_sequencer.sv
// Directed plus randomized bench for kan_tda_bist_sequencer; expected stimulus and
// signatures come from a spec-level model (sequence arrays and arithmetic).
module tb_kan_tda_bist_sequencer;

    localparam int          DW   = 16;
    localparam int          NL   = 4;
    localparam int          BW   = DW * NL;
    localparam logic [31:0] SEED = 32'h0000ACE1;

    logic          sys_clk = 1'b0;
    logic          por_rst_n;
    logic          bist_start, bist_abort, stim_ready, resp_valid;
    logic [15:0]   cfg_num_vectors;
    logic [31:0]   cfg_golden_sig;
    logic [BW-1:0] stim_data, resp_data;
    logic          stim_valid, bist_busy, bist_done, bist_pass, bist_timeout, bist_spurious;
    logic [15:0]   vec_count;
    logic [31:0]   signature;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [31:0]   m_lfsr, m_sig;
    logic [BW-1:0] resp_tab [0:15];

    always #5 sys_clk = ~sys_clk;

    kan_tda_bist_sequencer #(
        .DATA_WIDTH(DW), .NUM_LANES(NL), .TIMEOUT_CYCLES(1024), .LFSR_SEED(SEED)
    ) dut (
        .sys_clk(sys_clk), .por_rst_n(por_rst_n), .bist_start(bist_start),
        .bist_abort(bist_abort), .cfg_num_vectors(cfg_num_vectors),
        .cfg_golden_sig(cfg_golden_sig), .stim_data(stim_data), .stim_valid(stim_valid),
        .stim_ready(stim_ready), .resp_data(resp_data), .resp_valid(resp_valid),
        .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
        .bist_timeout(bist_timeout), .bist_spurious(bist_spurious),
        .vec_count(vec_count), .signature(signature)
    );

    function automatic logic [31:0] ref_lfsr(input logic [31:0] x);
        logic [31:0] taps;
        taps = (x % 32'd2 == 32'd1) ? 32'h80200003 : 32'h00000000;
        return (x / 32'd2) ^ taps;
    endfunction

    function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [31:0] f);
        logic [32:0] dbl;
        dbl = {1'b0, s} * 33'd2;
        return dbl[31:0] ^ (dbl[32] ? 32'h04C11DB7 : 32'h00000000) ^ f;
    endfunction

    function automatic logic [BW-1:0] ref_stim(input logic [31:0] l);
        logic [BW-1:0] v;
        logic [DW-1:0] base;
        base = l[DW-1:0];
        v = '0;
        for (int k = 0; k < NL; k++) v[k*DW +: DW] = base ^ DW'(k);
        return v;
    endfunction

    function automatic logic [31:0] ref_fold(input logic [BW-1:0] r);
        logic [31:0] f;
        f = 32'h00000000;
        for (int k = 0; k < NL; k++) f = f ^ {16'h0000, r[k*DW +: DW]};
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic start_run(input int n, input logic [31:0] golden);
        cfg_num_vectors = n[15:0];
        cfg_golden_sig  = golden;
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        chk("seed_busy", {63'd0, bist_busy}, 64'd1);
        chk("seed_no_valid", {63'd0, stim_valid}, 64'd0);
        tick();
    endtask

    // One BIST run against the model; abort_at < 0 means run to completion.
    task automatic run(input int n, input int abort_at, input bit rnd, input bit spur,
                       input bit golden_ok);
        logic [31:0] exp_sig;
        int          stall, dly;
        m_lfsr  = SEED;
        m_sig   = 32'hFFFFFFFF;
        exp_sig = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            resp_tab[i] = rnd ? {$urandom(), $urandom()} : {BW{1'b0}};
            exp_sig     = ref_misr(exp_sig, ref_fold(resp_tab[i]));
        end
        start_run(n, golden_ok ? exp_sig : ~exp_sig);
        for (int v = 0; v < n; v++) begin
            chk("stim_valid", {63'd0, stim_valid}, 64'd1);
            chk("stim_data", stim_data, ref_stim(m_lfsr));
            stall = rnd ? int'($urandom_range(0, 3)) : 0;
            if (spur && v == 0) stall = 2;
            for (int s = 0; s < stall; s++) begin
                if (spur && v == 0 && s == 0) resp_valid = 1'b1;
                tick();
                resp_valid = 1'b0;
                chk("stall_valid", {63'd0, stim_valid}, 64'd1);
                chk("stall_data", stim_data, ref_stim(m_lfsr));
            end
            if (spur && v == 0) chk("spurious_set", {63'd0, bist_spurious}, 64'd1);
            stim_ready = 1'b1;
            tick();
            stim_ready = 1'b0;
            m_lfsr = ref_lfsr(m_lfsr);
            chk("valid_drop", {63'd0, stim_valid}, 64'd0);
            if (v == abort_at) begin
                bist_abort = 1'b1;
                bist_start = 1'b1;
                tick();
                bist_abort = 1'b0;
                bist_start = 1'b0;
                chk("abort_busy", {63'd0, bist_busy}, 64'd0);
                chk("abort_done", {63'd0, bist_done}, 64'd0);
                chk("abort_valid", {63'd0, stim_valid}, 64'd0);
                chk("abort_vec", {48'd0, vec_count}, 64'(abort_at));
                chk("abort_sig", {32'd0, signature}, {32'd0, m_sig});
                tick();
                chk("abort_stays_idle", {63'd0, bist_busy}, 64'd0);
                return;
            end
            dly = rnd ? int'($urandom_range(0, 4)) : 2;
            repeat (dly) tick();
            resp_data  = resp_tab[v];
            resp_valid = 1'b1;
            tick();
            resp_valid = 1'b0;
            resp_data  = {BW{1'b0}};
            m_sig = ref_misr(m_sig, ref_fold(resp_tab[v]));
            chk("vec_count", {48'd0, vec_count}, 64'(v + 1));
            chk("signature", {32'd0, signature}, {32'd0, m_sig});
        end
        chk("check_not_done", {63'd0, bist_done}, 64'd0);
        tick();
        chk("done", {63'd0, bist_done}, 64'd1);
        chk("pass", {63'd0, bist_pass}, {63'd0, (golden_ok && !spur)});
        chk("timeout_clear", {63'd0, bist_timeout}, 64'd0);
        chk("final_sig", {32'd0, signature}, {32'd0, exp_sig});
    endtask

    initial begin
        por_rst_n = 1'b0; bist_start = 1'b0; bist_abort = 1'b0; stim_ready = 1'b0;
        resp_valid = 1'b0; resp_data = {BW{1'b0}};
        cfg_num_vectors = 16'd0; cfg_golden_sig = 32'h00000000;
        repeat (3) tick();
        por_rst_n = 1'b1;
        tick();
        chk("rst_busy", {63'd0, bist_busy}, 64'd0);
        chk("rst_done", {63'd0, bist_done}, 64'd0);
        chk("rst_valid", {63'd0, stim_valid}, 64'd0);
        chk("rst_stim", stim_data, 64'd0);
        chk("rst_sig", {32'd0, signature}, 64'h00000000FFFFFFFF);
        chk("rst_vec", {48'd0, vec_count}, 64'd0);
        chk("rst_flags", {61'd0, bist_pass, bist_timeout, bist_spurious}, 64'd0);

        // Single echo-zero vector, matching then mismatching golden.
        run(1, -1, 1'b0, 1'b0, 1'b1);
        chk("t1_sig_const", {32'd0, signature}, 64'h00000000FB3EE249);
        chk("t1_vec", {48'd0, vec_count}, 64'd1);
        run(1, -1, 1'b0, 1'b0, 1'b0);

        // Zero vectors: SEED, CHECK, DONE.
        start_run(0, 32'hFFFFFFFF);
        chk("z_no_valid", {63'd0, stim_valid}, 64'd0);
        chk("z_not_done", {63'd0, bist_done}, 64'd0);
        tick();
        chk("z_done", {63'd0, bist_done}, 64'd1);
        chk("z_pass", {63'd0, bist_pass}, 64'd1);
        chk("z_sig", {32'd0, signature}, 64'h00000000FFFFFFFF);

        // Held-off ready for 20 cycles, then a silent responder.
        start_run(1, 32'h00000000);
        chk("lane0", {48'd0, stim_data[15:0]}, 64'h000000000000ACE1);
        chk("lane3", {48'd0, stim_data[63:48]}, 64'h000000000000ACE2);
        repeat (20) begin
            tick();
            chk("hold_data", stim_data, ref_stim(SEED));
        end
        stim_ready = 1'b1;
        tick();
        stim_ready = 1'b0;
        repeat (1023) tick();
        chk("wd_not_yet", {63'd0, bist_timeout}, 64'd0);
        chk("wd_busy", {63'd0, bist_busy}, 64'd1);
        tick();
        chk("wd_fired", {63'd0, bist_timeout}, 64'd1);
        chk("wd_not_done", {63'd0, bist_done}, 64'd0);
        tick();
        chk("wd_done", {63'd0, bist_done}, 64'd1);
        chk("wd_pass", {63'd0, bist_pass}, 64'd0);
        chk("wd_vec", {48'd0, vec_count}, 64'd0);

        // Randomized runs, a spurious response, and abort with rerun.
        run(10, -1, 1'b1, 1'b0, 1'b1);
        run(6, -1, 1'b1, 1'b0, 1'b0);
        run(2, -1, 1'b1, 1'b1, 1'b1);
        run(10, 5, 1'b1, 1'b0, 1'b1);
        run(3, -1, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of DRIVE.
        start_run(3, 32'h00000000);
        chk("mid_valid", {63'd0, stim_valid}, 64'd1);
        #2 por_rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, stim_valid}, 64'd0);
        chk("arst_busy", {63'd0, bist_busy}, 64'd0);
        chk("arst_sig", {32'd0, signature}, 64'h00000000FFFFFFFF);
        chk("arst_stim", stim_data, 64'd0);
        tick();
        por_rst_n = 1'b1;
        tick();
        chk("arst_idle", {63'd0, bist_busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/kan_tda_bist_sequencer.md
Name: kan_tda_bist_sequencer

Overview:
Synthesizable on-chip built-in self-test sequencer for the KAN/TDA compute array. It generates LFSR pseudo-random stimulus across a parametrised number of lanes and drives one vector at a time into the datapath through a valid/ready handshake. Responses are compacted into a 32-bit MISR signature, which is compared against a programmed golden value. A per-vector response watchdog catches a hung datapath. It sits between the configuration/JTAG register block and the compute array's data ingress/egress.

Parameters:
DATA_WIDTH, 16, lane width in bits; legal range 8..32.
NUM_LANES, 4, parallel stimulus/response lanes.
TIMEOUT_CYCLES, 1024, maximum wait for resp_valid per vector; must be at least 2.
LFSR_SEED, 32'h0000ACE1, LFSR load value; must be non-zero.

Ports:
sys_clk  in  1  system clock
por_rst_n  in  1  asynchronous active-low reset
bist_start  in  1  start request, sampled in IDLE and DONE
bist_abort  in  1  abort request, takes priority over every other input
cfg_num_vectors  in  16  number of vectors to run
cfg_golden_sig  in  32  expected final signature
stim_data  out  NUM_LANES*DATA_WIDTH  stimulus; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
stim_valid  out  1  stimulus valid
stim_ready  in  1  datapath accepts stimulus
resp_data  in  NUM_LANES*DATA_WIDTH  datapath response
resp_valid  in  1  response valid, single-cycle qualifier
bist_busy  out  1  high in SEED, DRIVE, WAIT_RESP
bist_done  out  1  high in DONE
bist_pass  out  1  valid when bist_done=1
bist_timeout  out  1  sticky watchdog flag
bist_spurious  out  1  sticky flag: resp_valid seen outside WAIT_RESP while busy
vec_count  out  16  vectors completed
signature  out  32  current MISR value

Behaviour:
- Reset values: all outputs 0 except signature=32'hFFFFFFFF. FSM resets to IDLE, LFSR resets to LFSR_SEED.
- States and transitions:
  - IDLE: on bist_start, go to SEED.
  - SEED: load LFSR=LFSR_SEED, signature=FFFFFFFF, vec_count=0, clear timeout/spurious/pass. If cfg_num_vectors==0, go to CHECK; otherwise go to DRIVE.
  - DRIVE: stim_valid=1, stim_data held stable. On stim_valid&&stim_ready, advance the LFSR once and go to WAIT_RESP.
  - WAIT_RESP: the watchdog counts from 0. On resp_valid, update the MISR, increment vec_count, and go to DRIVE, or to CHECK if vec_count+1==cfg_num_vectors. If the counter reaches TIMEOUT_CYCLES-1 with no resp_valid, set bist_timeout and go to CHECK.
  - CHECK: one cycle; bist_pass = (signature==cfg_golden_sig) && !bist_timeout && !bist_spurious. Go to DONE.
  - DONE: outputs held. On bist_start, go to SEED.
- Latency: bist_start to first stim_valid is 2 cycles (IDLE→SEED→DRIVE). The final resp_valid to bist_done is 2 cycles.
- cfg_num_vectors and cfg_golden_sig are sampled live. Software must hold them stable while busy.
- Stimulus: lane k = LFSR[DATA_WIDTH-1:0] XOR k, with k zero-extended. Lane values are combinational from the LFSR register.
- LFSR: 32-bit Galois, shift right. If bit0=1, next = (lfsr>>1) XOR 32'h80200003; otherwise next = lfsr>>1.
- MISR update: sig_next = {sig[30:0],1'b0} XOR (sig[31] ? 32'h04C11DB7 : 0) XOR F. F is the XOR of all lanes, each zero-extended to 32 bits.
- resp_valid in the same cycle as the DRIVE handshake is not captured; it sets bist_spurious.
- resp_valid in SEED, DRIVE or CHECK sets bist_spurious and is not compacted. In IDLE or DONE it is ignored.
- stim_valid must not drop without stim_ready, except on abort or reset.
- bist_abort in any state goes to IDLE next cycle:
  - clears stim_valid, busy and done;
  - leaves vec_count, signature and sticky flags frozen for debug;
  - bist_abort together with bist_start means abort wins.
- vec_count saturates at 16'hFFFF and does not wrap; cfg_num_vectors ≤ 65535 guarantees it.
- Asynchronous reset mid-run returns everything to reset values immediately and stim_valid deasserts.

Test Plan:
- Reset, then bist_start with cfg_num_vectors=1 and an echo-zero responder (resp_data=0, resp_valid 3 cycles after accept) -> stim lane0=16'hACE1 and lane3=16'hACE2. Final signature=32'hFB3EE249, vec_count=1. With cfg_golden_sig=FB3EE249: bist_done=1, bist_pass=1.
- Same as above with cfg_golden_sig=0 -> bist_done=1, bist_pass=0, bist_timeout=0.
- cfg_num_vectors=0 -> bist_done 3 cycles after start (SEED, CHECK, DONE), signature=FFFFFFFF, no stim_valid. Pass only when golden=FFFFFFFF.
- stim_ready held low for 20 cycles -> stim_valid stays 1 with stim_data constant; the LFSR advances only after ready. The watchdog does not run in DRIVE.
- Responder silent with TIMEOUT_CYCLES=1024 -> bist_timeout=1 at cycle 1024 of WAIT_RESP, then bist_done=1, bist_pass=0.
- Abort in WAIT_RESP after vector 5 of 10 -> IDLE next cycle, busy=0, done=0, vec_count=5. A later bist_start reruns from vec_count=0 and the identical first stimulus 0xACE1.
